pic_interrupt_sequencer: RTL and testbench

//  Synchronous scheduler for the 8259A-style interrupt path, all on one clock.

---
 rtl/pic_pkg.sv | 24 ++
 rtl/pic_priority_resolver.sv | 34 +++
 rtl/pic_interrupt_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pic_interrupt_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt sequencer.
//   seq_state_t      : acknowledge-sequencer FSM states
//   PIC_NUM_IRQ      : number of request lines (fixed at 8)
//   PIC_SPURIOUS_IDX : index reported when an INTA finds no winner
//   pic_rank()       : position of an index in the rotating priority order
package pic_pkg;

  localparam int unsigned PIC_NUM_IRQ      = 8;
  localparam logic [2:0]  PIC_SPURIOUS_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    WAIT2,
    ACK2
  } seq_state_t;

  // 0 = highest priority. Level lp+1 is highest, lp itself is lowest; 3-bit wrap.
  function automatic logic [2:0] pic_rank(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority encoder.
//   req   : request vector, bit i = level i
//   lp    : lowest-priority level; search order is lp+1, lp+2, ..., lp (mod 8)
//   valid : any request set
//   idx   : highest-priority set level (0 when valid=0)
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [PIC_NUM_IRQ-1:0] req,
  input  logic [2:0]             lp,
  output logic                   valid,
  output logic [2:0]             idx
);

  logic [3:0] pos;

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    pos   = 4'd0;
    // Walk from the lowest-priority slot (lp+8 == lp) up to lp+1 so the last hit wins.
    for (int k = 8; k >= 1; k--) begin
      pos = {1'b0, lp} + 4'(k);
      if (pos > 4'd7) begin
        pos = pos - 4'd8;
      end
      if (req[pos[2:0]]) begin
        valid = 1'b1;
        idx   = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259A-style interrupt sequencer: priority resolution, INT generation, two-pulse
// INTA sequencing, vector drive, EOI retirement and rotation pointer.
//   clk, rst                 : clock, synchronous active-high reset
//   irr, imr                 : pending requests, mask (1 = masked)
//   vector_base              : upper five vector bits
//   aeoi, rotate_en          : auto-EOI, rotate-on-EOI modes
//   eoi_valid/specific/level : EOI command strobe and qualifiers
//   inta_n                   : CPU acknowledge, active low, synchronous
//   int_out                  : interrupt request to the CPU
//   irr_clr                  : one-cycle one-hot clear of the acknowledged IRR bit
//   isr                      : in-service register
//   data_out, data_oe        : vector byte and its drive enable
//   busy                     : sequencer not idle
module pic_interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [4:0]         vector_base,
  input  logic               aeoi,
  input  logic               rotate_en,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [2:0]         eoi_level,
  input  logic               inta_n,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] irr_clr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [VEC_W-1:0]   data_out,
  output logic               data_oe,
  output logic               busy
);

  seq_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d, isr_set, eoi_clr, aeoi_clr;
  logic [NUM_IRQ-1:0] irr_clr_q, irr_clr_d;
  logic [2:0]         lp_q, lp_d, win_q, win_d, eoi_idx;
  logic               spur_q, spur_d, inta_q;
  logic               int_q, int_d, data_oe_q, data_oe_d;
  logic [VEC_W-1:0]   data_out_q, data_out_d;
  logic               eoi_hit, aeoi_rot, take_ack;

  logic [NUM_IRQ-1:0] cand;
  logic               cand_valid, isr_valid, winner, fall, rise;
  logic [2:0]         cand_idx, isr_idx;

  assign cand = irr & ~imr;
  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

  pic_priority_resolver u_cand_res (
    .req   (cand),
    .lp    (lp_q),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  pic_priority_resolver u_isr_res (
    .req   (isr_q),
    .lp    (lp_q),
    .valid (isr_valid),
    .idx   (isr_idx)
  );

  // Nesting: a candidate must strictly outrank the highest level already in service.
  assign winner = cand_valid &&
                  (!isr_valid || (pic_rank(cand_idx, lp_q) < pic_rank(isr_idx, lp_q)));

  always_comb begin
    state_d    = state_q;
    int_d      = int_q;
    irr_clr_d  = '0;
    isr_set    = '0;
    aeoi_clr   = '0;
    aeoi_rot   = 1'b0;
    win_d      = win_q;
    spur_d     = spur_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    take_ack   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // An INTA with no prior INT (e.g. after an aborting reset) still gets a vector.
        if (fall) begin
          take_ack = 1'b1;
        end else if (winner) begin
          int_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fall) begin
          take_ack = 1'b1;
        end else if (!winner) begin
          int_d   = 1'b0;
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (fall) begin
          data_oe_d  = 1'b1;
          data_out_d = VEC_W'({vector_base, win_q});
          state_d    = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          data_oe_d = 1'b0;
          if (aeoi && !spur_q) begin
            aeoi_clr[win_q] = 1'b1;
            aeoi_rot        = rotate_en;
          end
          spur_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // First INTA pulse: freeze the winner (or report spurious) for the rest of the cycle.
    if (take_ack) begin
      int_d   = 1'b0;
      state_d = ACK1;
      if (winner) begin
        win_d     = cand_idx;
        spur_d    = 1'b0;
        isr_set   = NUM_IRQ'(1) << cand_idx;
        irr_clr_d = NUM_IRQ'(1) << cand_idx;
      end else begin
        win_d  = PIC_SPURIOUS_IDX;
        spur_d = 1'b1;
      end
    end
  end

  always_comb begin
    eoi_clr = '0;
    eoi_hit = 1'b0;
    eoi_idx = 3'd0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_idx = eoi_level;
        eoi_hit = isr_q[eoi_level];
      end else begin
        eoi_idx = isr_idx;
        eoi_hit = isr_valid;
      end
      if (eoi_hit) eoi_clr[eoi_idx] = 1'b1;
    end
  end

  // Clears apply before the set so an EOI and an acknowledge in one cycle both land.
  assign isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;

  always_comb begin
    lp_d = lp_q;
    if (rotate_en && eoi_hit) lp_d = eoi_idx;
    if (aeoi_rot)             lp_d = win_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      isr_q      <= '0;
      irr_clr_q  <= '0;
      lp_q       <= 3'd7;
      win_q      <= 3'd0;
      spur_q     <= 1'b0;
      inta_q     <= 1'b1;
      int_q      <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      isr_q      <= isr_d;
      irr_clr_q  <= irr_clr_d;
      lp_q       <= lp_d;
      win_q      <= win_d;
      spur_q     <= spur_d;
      inta_q     <= inta_n;
      int_q      <= int_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign int_out  = int_q;
  assign irr_clr  = irr_clr_q;
  assign isr      = isr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
module tb_pic_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irr, imr;
  logic [4:0] vector_base;
  logic       aeoi, rotate_en, eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic       inta_n;
  logic       int_out, data_oe, busy;
  logic [7:0] irr_clr, isr, data_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_isr;
  int         m_lp;

  typedef struct packed {
    logic [7:0] isr_f1;
    logic [7:0] clr_f1;
    logic [7:0] clr_next;
    logic [7:0] vec;
    logic [7:0] isr_end;
    logic       oe;
    logic       oe_end;
    logic       int_f1;
  } obs_t;

  pic_interrupt_sequencer #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .irr          (irr),
    .imr          (imr),
    .vector_base  (vector_base),
    .aeoi         (aeoi),
    .rotate_en    (rotate_en),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .inta_n       (inta_n),
    .int_out      (int_out),
    .irr_clr      (irr_clr),
    .isr          (isr),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Highest-priority set bit when lp is the lowest level; -1 if none.
  function automatic int m_best(input logic [7:0] req, input int lp);
    for (int k = 1; k <= 8; k++) begin
      if (req[(lp + k) % 8]) return (lp + k) % 8;
    end
    return -1;
  endfunction

  function automatic int m_rank(input int i, input int lp);
    return (i - lp + 7) % 8;
  endfunction

  function automatic int m_winner();
    int c, t;
    c = m_best(irr & ~imr, m_lp);
    t = m_best(m_isr, m_lp);
    if (c < 0) return -1;
    if (t < 0) return c;
    return (m_rank(c, m_lp) < m_rank(t, m_lp)) ? c : -1;
  endfunction

  function automatic void m_eoi(input bit spec, input int lvl);
    int t;
    if (spec) t = m_isr[lvl] ? lvl : -1;
    else      t = m_best(m_isr, m_lp);
    if (t >= 0) begin
      m_isr[t] = 1'b0;
      if (rotate_en) m_lp = t;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_eoi(input bit spec, input int lvl);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = 3'(lvl);
    m_eoi(spec, lvl);
    tick();
    eoi_valid = 1'b0;
  endtask

  // Full two-pulse INTA cycle; optional EOI in the same cycle as the first fall.
  task automatic inta_pair(input bit eoi_now, input bit eoi_spec, input int eoi_lvl,
                           output obs_t o, output obs_t e);
    int w;
    w = m_winner();
    e.int_f1   = 1'b0;
    e.oe       = 1'b1;
    e.oe_end   = 1'b0;
    e.clr_next = 8'h00;
    e.clr_f1   = (w >= 0) ? 8'(1 << w) : 8'h00;
    e.vec      = {vector_base, (w >= 0) ? 3'(w) : 3'd7};
    if (eoi_now) m_eoi(eoi_spec, eoi_lvl);
    if (w >= 0) m_isr[w] = 1'b1;
    e.isr_f1 = m_isr;
    eoi_valid    = eoi_now;
    eoi_specific = eoi_spec;
    eoi_level    = 3'(eoi_lvl);
    inta_n = 1'b0;
    tick();
    eoi_valid = 1'b0;
    o.isr_f1 = isr;
    o.clr_f1 = irr_clr;
    o.int_f1 = int_out;
    if (w >= 0) irr[w] = 1'b0;
    inta_n = 1'b1;
    tick();
    o.clr_next = irr_clr;
    inta_n = 1'b0;
    tick();
    o.vec = data_out;
    o.oe  = data_oe;
    tick();
    inta_n = 1'b1;
    tick();
    o.oe_end  = data_oe;
    o.isr_end = isr;
    if (aeoi && w >= 0) begin
      m_isr[w] = 1'b0;
      if (rotate_en) m_lp = w;
    end
    e.isr_end = m_isr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    irr = 8'h00; imr = 8'h00; vector_base = 5'h08;
    aeoi = 1'b0; rotate_en = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
    eoi_level = 3'd0; inta_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({int_out, irr_clr, isr, data_out, data_oe, busy} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got int=%b clr=%h isr=%h dout=%h oe=%b busy=%b, want all 0",
               int_out, irr_clr, isr, data_out, data_oe, busy);
    end
    rst = 1'b0;
    m_isr = 8'h00;
    m_lp  = 7;
  endtask

  task automatic test_single();
    obs_t o, e;
    irr = 8'h08;
    n_tests++;
    if (int_out !== 1'b0) begin
      n_fail++; $display("FAIL single_int_early: got %b want 0", int_out);
    end
    tick();
    n_tests++;
    if (int_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_int: got int=%b busy=%b want 1 1", int_out, busy);
    end
    inta_pair(1'b0, 1'b0, 0, o, e);
    n_tests++;
    if (o.isr_f1 !== 8'h08 || o.clr_f1 !== 8'h08 || o.int_f1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fall1: got isr=%h clr=%h int=%b want 08 08 0",
               o.isr_f1, o.clr_f1, o.int_f1);
    end
    n_tests++;
    if (o.clr_next !== 8'h00) begin
      n_fail++; $display("FAIL single_clr_pulse: got %h want 00", o.clr_next);
    end
    n_tests++;
    if (o.vec !== 8'h43 || o.oe !== 1'b1 || o.oe_end !== 1'b0) begin
      n_fail++;
      $display("FAIL single_vector: got %h oe=%b oe_end=%b want 43 1 0", o.vec, o.oe, o.oe_end);
    end
    do_eoi(1'b0, 0);
    n_tests++;
    if (isr !== 8'h00) begin
      n_fail++; $display("FAIL single_eoi: got isr=%h want 00", isr);
    end
  endtask

  task automatic test_nesting();
    obs_t o, e;
    irr = 8'h08;
    tick();
    inta_pair(1'b0, 1'b0, 0, o, e);
    irr = 8'h81;
    tick();
    n_tests++;
    if (int_out !== 1'b1) begin
      n_fail++; $display("FAIL nest_int: got %b want 1", int_out);
    end
    inta_pair(1'b0, 1'b0, 0, o, e);
    n_tests++;
    if (o.isr_f1 !== 8'h09 || o.vec !== 8'h40 || o.isr_f1 !== e.isr_f1) begin
      n_fail++; $display("FAIL nest_ack: got isr=%h vec=%h want 09 40", o.isr_f1, o.vec);
    end
    tick();
    n_tests++;
    if (int_out !== 1'b0) begin
      n_fail++; $display("FAIL nest_blocked: got int=%b want 0", int_out);
    end
    do_eoi(1'b0, 0);
    tick();
    n_tests++;
    if (int_out !== 1'b0 || isr !== 8'h08) begin
      n_fail++; $display("FAIL nest_eoi1: got int=%b isr=%h want 0 08", int_out, isr);
    end
    do_eoi(1'b0, 0);
    tick();
    n_tests++;
    if (int_out !== 1'b1 || m_winner() != 7) begin
      n_fail++; $display("FAIL nest_reassert: got int=%b want 1", int_out);
    end
    inta_pair(1'b0, 1'b0, 0, o, e);
    n_tests++;
    if (o.vec !== 8'h47 || o.isr_f1 !== 8'h80) begin
      n_fail++; $display("FAIL nest_ir7: got vec=%h isr=%h want 47 80", o.vec, o.isr_f1);
    end
    do_eoi(1'b0, 0);
  endtask

  task automatic test_spurious();
    obs_t o, e;
    irr = 8'h04;
    tick();
    n_tests++;
    if (int_out !== 1'b1) begin
      n_fail++; $display("FAIL spur_int: got %b want 1", int_out);
    end
    irr = 8'h00;
    inta_pair(1'b0, 1'b0, 0, o, e);
    n_tests++;
    if (o.vec !== 8'h47 || o.isr_f1 !== 8'h00 || o.clr_f1 !== 8'h00 || o.isr_end !== 8'h00) begin
      n_fail++;
      $display("FAIL spur_vector: got vec=%h isr=%h clr=%h isr_end=%h want 47 00 00 00",
               o.vec, o.isr_f1, o.clr_f1, o.isr_end);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o, e;
    irr = 8'h20;
    tick();
    inta_pair(1'b0, 1'b0, 0, o, e);
    irr = 8'h02;
    tick();
    inta_pair(1'b1, 1'b1, 5, o, e);
    n_tests++;
    if (o.isr_f1 !== 8'h02 || o.vec !== 8'h41) begin
      n_fail++; $display("FAIL simul_eoi_ack: got isr=%h vec=%h want 02 41", o.isr_f1, o.vec);
    end
    do_eoi(1'b0, 0);
    n_tests++;
    if (isr !== 8'h00) begin
      n_fail++; $display("FAIL simul_cleanup: got isr=%h want 00", isr);
    end
  endtask

  task automatic test_auto_eoi();
    obs_t o, e;
    aeoi = 1'b1;
    rotate_en = 1'b1;
    irr = 8'h04;
    tick();
    inta_pair(1'b0, 1'b0, 0, o, e);
    n_tests++;
    if (o.isr_f1 !== 8'h04 || o.isr_end !== 8'h00 || o.vec !== 8'h42) begin
      n_fail++;
      $display("FAIL aeoi_ir2: got isr=%h isr_end=%h vec=%h want 04 00 42",
               o.isr_f1, o.isr_end, o.vec);
    end
    irr = 8'h03;
    tick();
    inta_pair(1'b0, 1'b0, 0, o, e);
    irr = 8'h00;
    n_tests++;
    if (o.vec !== 8'h40 || o.isr_end !== 8'h00) begin
      n_fail++; $display("FAIL aeoi_rotate: got vec=%h isr_end=%h want 40 00", o.vec, o.isr_end);
    end
    aeoi = 1'b0;
    rotate_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    irr = 8'h02;
    tick();
    inta_n = 1'b0;
    tick();
    irr = 8'h00;
    inta_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b1 || isr !== 8'h02) begin
      n_fail++; $display("FAIL mid_pre: got busy=%b isr=%h want 1 02", busy, isr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_isr = 8'h00;
    m_lp  = 7;
    n_tests++;
    if ({int_out, irr_clr, isr, data_out, data_oe, busy} !== 27'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got int=%b clr=%h isr=%h dout=%h oe=%b busy=%b, want all 0",
               int_out, irr_clr, isr, data_out, data_oe, busy);
    end
    inta_pair(1'b0, 1'b0, 0, o, e);
    n_tests++;
    if (o.vec !== 8'h47 || o.oe !== 1'b1 || o.isr_end !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_spurious: got vec=%h oe=%b isr=%h want 47 1 00", o.vec, o.oe, o.isr_end);
    end
    // lp must be back at 7: IR0 outranks IR7.
    irr = 8'h81;
    tick();
    inta_pair(1'b0, 1'b0, 0, o, e);
    irr = 8'h00;
    n_tests++;
    if (o.vec !== 8'h40) begin
      n_fail++; $display("FAIL mid_lp: got vec=%h want 40", o.vec);
    end
    do_eoi(1'b0, 0);
  endtask

  task automatic test_random();
    obs_t o, e;
    int   w;
    for (int it = 0; it < 40; it++) begin
      irr = 8'h00;
      aeoi = 1'($urandom_range(0, 1));
      rotate_en = 1'($urandom_range(0, 1));
      vector_base = 5'($urandom);
      tick();
      tick();
      if ($urandom_range(0, 1) == 1) do_eoi(1'($urandom_range(0, 1)), $urandom_range(0, 7));
      n_tests++;
      if (isr !== m_isr) begin
        n_fail++; $display("FAIL rand_isr[%0d]: got %h want %h", it, isr, m_isr);
      end
      imr = 8'($urandom) & 8'($urandom);
      irr = 8'($urandom);
      w = m_winner();
      tick();
      n_tests++;
      if (int_out !== (w >= 0)) begin
        n_fail++; $display("FAIL rand_int[%0d]: got %b want %b", it, int_out, (w >= 0));
      end
      if (w >= 0 || $urandom_range(0, 3) == 0) begin
        inta_pair(1'b0, 1'b0, 0, o, e);
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL rand_ack[%0d]: got vec=%h isr=%h clr=%h end=%h, want vec=%h isr=%h clr=%h end=%h",
                   it, o.vec, o.isr_f1, o.clr_f1, o.isr_end, e.vec, e.isr_f1, e.clr_f1, e.isr_end);
        end
      end
    end
    irr = 8'h00;
    imr = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_nesting();
    test_spurious();
    test_simultaneous();
    test_auto_eoi();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
